// File: rtl/ifstage_fsm.sv
// Instruction-fetch stage: Moore FSM (IDLE/FETCH/ISSUE/FAULT). It owns the PC, requests
// instructions from IMem and holds each fetched word for the control decoder.
// Latency: Instr_Valid rises one edge after IMem_Ack. The next IMem_Req rises one edge after PC_LdEn.
// Backpressure: ISSUE holds Instr and PC until PC_LdEn. FETCH times out into a sticky FAULT.
//
// Ports:
//   Clk, Reset      - single clock; synchronous active-low reset
//   PC_Sel          - 0: next PC = PC+4, 1: next PC = PC+4+(PC_Immed<<2)
//   PC_LdEn         - consumer accepts Instr and lets the PC advance (honoured in ISSUE only)
//   PC_Immed        - sign-extended branch offset in words
//   IMem_Ack        - read data valid (honoured in FETCH only)
//   IMem_RData      - read data
//   IMem_Req        - read request, high exactly while in FETCH
//   IMem_Addr       - read address (always the PC)
//   PC              - current program counter
//   Instr           - registered instruction word
//   Instr_Valid     - high exactly while in ISSUE
//   Fetch_Err       - sticky timeout flag, cleared only by reset
module ifstage_fsm #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        PC_Sel,
    input  logic        PC_LdEn,
    input  logic [31:0] PC_Immed,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_RData,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    output logic [31:0] PC,
    output logic [31:0] Instr,
    output logic        Instr_Valid,
    output logic        Fetch_Err
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_inc;
    logic          w_wait_hit;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic          r_fetch_err;
    logic [31:0]   w_pc_seq;
    logic [31:0]   w_pc_br;

    // The timeout fires on the edge where the incremented count reaches the
    // limit. An acknowledge on that same edge takes priority, so the
    // boundary cycle still completes the fetch.
    assign w_wait_inc = r_wait_cnt + CW'(1);
    assign w_wait_hit = (w_wait_inc == WAIT_LIMIT);

    // Carries out of bit 31 are discarded, so the PC wraps silently.
    assign w_pc_seq = r_pc + 32'd4;
    assign w_pc_br  = w_pc_seq + (PC_Immed << 2);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (IMem_Ack) begin
                    w_state_nxt = S_ISSUE;
                end else if (w_wait_hit) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_ISSUE: begin
                if (PC_LdEn) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FAULT: w_state_nxt = S_FAULT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= 32'h0;
            r_wait_cnt  <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_FETCH: begin
                    if (IMem_Ack) begin
                        r_instr    <= IMem_RData;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= w_wait_inc;
                        if (w_wait_hit) begin
                            r_fetch_err <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (PC_LdEn) begin
                        r_pc <= PC_Sel ? w_pc_br : w_pc_seq;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state, so reset and FAULT
    // force them low without extra gating.
    assign IMem_Req    = (r_state == S_FETCH);
    assign Instr_Valid = (r_state == S_ISSUE);
    assign IMem_Addr   = r_pc;
    assign PC          = r_pc;
    assign Instr       = r_instr;
    assign Fetch_Err   = r_fetch_err;

endmodule

// File: doc/ifstage_fsm.md
IFSTAGE_FSM -- requirements
Module: ifstage_fsm

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have parameter MAX_WAIT, default 15, the number of FETCH cycles without IMem_Ack before fault.
REQ-003 SHALL have port Clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port PC_Sel  in  1  branch select from control: 0 = PC+4, 1 = branch target.
REQ-006 SHALL have port PC_LdEn  in  1  consumer accepts the current Instr and permits the PC update.
REQ-007 SHALL have port PC_Immed  in  32  sign-extended branch offset, in words.
REQ-008 SHALL have port IMem_Ack  in  1  instruction memory read data valid.
REQ-009 SHALL have port IMem_RData  in  32  instruction memory read data.
REQ-010 SHALL have port IMem_Req  out  1  instruction memory read request.
REQ-011 SHALL have port IMem_Addr  out  32  read address, equal to PC.
REQ-012 SHALL have port PC  out  32  current program counter.
REQ-013 SHALL have port Instr  out  32  registered instruction for the control decoder.
REQ-014 SHALL have port Instr_Valid  out  1  Instr holds a fetched, unconsumed instruction.
REQ-015 SHALL have port Fetch_Err  out  1  sticky fetch-timeout fault flag.

Function
REQ-016 SHALL implement a Moore FSM with states IDLE, FETCH, ISSUE and FAULT.
REQ-017 In IDLE, the FSM SHALL move to FETCH on the next edge, unconditionally.
REQ-018 In FETCH, IMem_Req SHALL be 1 and IMem_Addr SHALL equal PC, held stable until acknowledge or fault.
REQ-019 In FETCH with IMem_Ack=1, on that edge Instr SHALL load IMem_RData, the wait counter SHALL clear and the FSM SHALL move to ISSUE.
REQ-020 In FETCH with IMem_Ack=0, the wait counter SHALL increment; when it reaches MAX_WAIT the FSM SHALL move to FAULT.
REQ-021 If IMem_Ack=1 in the same cycle the counter would reach MAX_WAIT, the acknowledge SHALL win and the FSM SHALL move to ISSUE.
REQ-022 In ISSUE, Instr_Valid SHALL be 1 and Instr SHALL stay constant until PC_LdEn=1.
REQ-023 In ISSUE with PC_LdEn=1, on that edge PC SHALL load PC_Sel ? PC+4+(PC_Immed<<2) : PC+4, and the FSM SHALL move to FETCH.
REQ-024 PC arithmetic SHALL be 32-bit modulo 2^32; carries out of bit 31 are discarded, so wrap-around is silent.
REQ-025 PC_LdEn, PC_Sel and PC_Immed SHALL be ignored outside ISSUE.
REQ-026 IMem_Ack and IMem_RData SHALL be ignored outside FETCH.
REQ-027 In FAULT: Fetch_Err SHALL be 1, IMem_Req SHALL be 0, Instr_Valid SHALL be 0, and PC SHALL be frozen; only reset exits FAULT.
REQ-028 Instr_Valid and IMem_Req SHALL never be 1 in the same cycle.
REQ-029 Fetch-to-issue latency SHALL be one edge after IMem_Ack; issue-to-next-request latency SHALL be one edge after PC_LdEn.

Reset
REQ-030 With Reset=0 at an edge, the block SHALL set: state IDLE, PC=RESET_PC, Instr=0, wait counter=0, Fetch_Err=0.
REQ-031 During reset, IMem_Req=0 and Instr_Valid=0; these are derived from state only.
REQ-032 Reset asserted mid-FETCH or mid-ISSUE SHALL abandon the transaction; a late IMem_Ack arriving after reset SHALL be ignored.
REQ-033 The first IMem_Req SHALL assert in the second cycle after Reset returns to 1 (IDLE, then FETCH).

Verification
REQ-034 Sequential fetch: IMem_Ack one cycle after Req with RData=32'h8000_0010, then PC_LdEn=1, PC_Sel=0 -> Instr=32'h8000_0010, Instr_Valid=1, next IMem_Addr=4.
REQ-035 Branch: PC=32'h40, PC_Immed=32'hFFFF_FFFE, PC_Sel=1, PC_LdEn=1 in ISSUE -> PC=32'h3C.
REQ-036 Timeout: IMem_Ack held 0 for 15 FETCH cycles -> Fetch_Err=1, IMem_Req=0, PC unchanged; it stays so until Reset=0.
REQ-037 Boundary: IMem_Ack=1 on the 15th wait cycle -> ISSUE entered, Fetch_Err=0. Separately, PC=32'hFFFF_FFFC with PC_Sel=0 -> PC=0.
REQ-038 Stall and reset: PC_LdEn=0 for 10 cycles in ISSUE -> Instr and PC stable, no Req. Reset=0 during FETCH, then a late Ack -> PC=RESET_PC, Instr=0, Instr_Valid=0.
